// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog
// Programmable UART baud-tick generator. A period counter runs against a
// run-time divisor and emits an oversampling tick (o_tick). Every
// OVERSAMPLE-th tick is also flagged as a bit tick (o_bit_tick).
// A newly written divisor is only held as pending while a period is running.
// It is applied at the end of that period, so the current period always
// finishes at the old rate. While the generator is idle or resyncing, the
// pending divisor is applied at once.
//
// Optional feature macro: BAUD_FRAC_EN
//   When defined, an NB_FRAC-bit fractional accumulator stretches selected
//   periods by one cycle. The average period is then
//   div_active + frac_active/2^NB_FRAC cycles.
//
// Ports:
//   i_clk, i_reset     clock; synchronous active-high reset
//   i_enable           count enable (low freezes counters, no ticks)
//   i_div_wr           strobe that captures i_div_value / i_frac_value as pending
//   i_div_value        integer divisor (cycles per o_tick); 0 and 1 act as 1
//   i_frac_value       fractional part (used only with BAUD_FRAC_EN)
//   i_resync           restart period and bit phase from zero
//   o_tick             one-cycle oversampling tick
//   o_bit_tick         one-cycle bit tick (the last tick of each OVERSAMPLE group)
//   o_div_active       divisor currently in use
module uart_baud_gen_prog #(
  parameter int NB_DIV     = 16,
  parameter int DIV_RESET  = 326,
  parameter int OVERSAMPLE = 16,
  parameter int NB_FRAC    = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_div_wr,
  input  logic [NB_DIV-1:0]  i_div_value,
  input  logic [NB_FRAC-1:0] i_frac_value,
  input  logic               i_resync,
  output logic               o_tick,
  output logic               o_bit_tick,
  output logic [NB_DIV-1:0]  o_div_active
);

  localparam int NB_PH = $clog2(OVERSAMPLE);
  localparam logic [NB_PH-1:0] PH_LAST = NB_PH'(OVERSAMPLE - 1);

  logic [NB_DIV-1:0] counter_q, counter_d;
  logic [NB_PH-1:0]  phase_q, phase_d;
  logic [NB_DIV-1:0] div_active_q, div_active_d;
  logic [NB_DIV-1:0] div_pending_q, div_pending_d;
  logic              pend_valid_q, pend_valid_d;

  logic              extra;
  logic [NB_DIV-1:0] tc;
  logic              tick;
  logic              apply_evt;
  logic              do_apply;

`ifdef BAUD_FRAC_EN
  logic [NB_FRAC-1:0] frac_active_q, frac_active_d;
  logic [NB_FRAC-1:0] frac_pending_q, frac_pending_d;
  logic [NB_FRAC-1:0] frac_acc_q, frac_acc_d;
  logic               carry_q, carry_d;   // stretches the current period by one cycle

  assign extra = carry_q;
`else
  logic unused_frac;

  assign extra       = 1'b0;
  assign unused_frac = ^i_frac_value;
`endif

  assign tc = div_active_q - NB_DIV'(1) + NB_DIV'(extra);

  always_comb begin
    // Reset also masks the tick, so a period cut short by reset never emits one.
    tick      = i_enable & ~i_resync & ~i_reset & (counter_q == tc);
    apply_evt = tick | ~i_enable | i_resync;

    // A write arriving in the same cycle as the apply event wins directly.
    div_pending_d = i_div_wr ? i_div_value : div_pending_q;
    do_apply      = apply_evt & (i_div_wr | pend_valid_q);
    pend_valid_d  = (i_div_wr | pend_valid_q) & ~apply_evt;

    div_active_d = div_active_q;
    if (do_apply)
      div_active_d = (div_pending_d < NB_DIV'(2)) ? NB_DIV'(1) : div_pending_d;

    counter_d = counter_q;
    phase_d   = phase_q;
    if (i_resync) begin
      counter_d = '0;
      phase_d   = '0;
    end else if (i_enable) begin
      counter_d = tick ? '0 : counter_q + NB_DIV'(1);
      if (tick)
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + NB_PH'(1);
    end
  end

`ifdef BAUD_FRAC_EN
  always_comb begin
    frac_pending_d = i_div_wr ? i_frac_value : frac_pending_q;
    frac_active_d  = do_apply ? frac_pending_d : frac_active_q;
    frac_acc_d     = frac_acc_q;
    carry_d        = carry_q;
    if (i_resync) begin
      frac_acc_d = '0;
      carry_d    = 1'b0;
    end else if (tick) begin
      // The carry out of this period's accumulation lengthens the next period.
      {carry_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, frac_active_q};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frac_active_q  <= '0;
      frac_pending_q <= '0;
      frac_acc_q     <= '0;
      carry_q        <= 1'b0;
    end else begin
      frac_active_q  <= frac_active_d;
      frac_pending_q <= frac_pending_d;
      frac_acc_q     <= frac_acc_d;
      carry_q        <= carry_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      counter_q     <= '0;
      phase_q       <= '0;
      div_active_q  <= NB_DIV'(DIV_RESET);
      div_pending_q <= NB_DIV'(DIV_RESET);
      pend_valid_q  <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      phase_q       <= phase_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      pend_valid_q  <= pend_valid_d;
    end
  end

  assign o_tick       = tick;
  assign o_bit_tick   = tick & (phase_q == PH_LAST);
  assign o_div_active = div_active_q;

endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// Testbench for uart_baud_gen_prog (default build, fractional feature off).
// Stimulus pushes expected tick cycles, each with its bit-tick flag, into a
// queue. A monitor on the falling edge pops entries and compares them
// against o_tick / o_bit_tick. Cycle 1 is the first cycle after reset is
// released.
module tb_uart_baud_gen_prog;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_div_wr = 1'b0;
  logic [15:0] i_div_value = '0;
  logic [3:0]  i_frac_value = '0;
  logic        i_resync = 1'b0;
  logic        o_tick;
  logic        o_bit_tick;
  logic [15:0] o_div_active;

  uart_baud_gen_prog dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_div_wr     (i_div_wr),
    .i_div_value  (i_div_value),
    .i_frac_value (i_frac_value),
    .i_resync     (i_resync),
    .o_tick       (o_tick),
    .o_bit_tick   (o_bit_tick),
    .o_div_active (o_div_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit bt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) begin
    if (i_reset) cyc <= 1;
    else         cyc <= cyc + 1;
  end

  task automatic push(input int c, input bit b);
    exp_t e;
    e.cyc = c;
    e.bt  = b;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (i_reset) begin
      chk("reset_outputs", int'(o_tick) + int'(o_bit_tick), 0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_tick: no tick seen, expected at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (o_tick) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          chk("bit_tick", int'(o_bit_tick), int'(q[0].bt));
          void'(q.pop_front());
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tick: tick at cycle %0d, next expected %0d",
                   cyc, (q.size() > 0) ? q[0].cyc : -1);
        end
      end else if (o_bit_tick) begin
        chk("bit_without_tick", 1, 0);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit en);
    @(posedge clk);
    #1;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_div_wr = 1'b0;
    i_resync = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("reset_div_active", int'(o_div_active), 326);
    i_reset  = 1'b0;
    i_enable = en;
  endtask

  task automatic wr(input int c, input int d, input int f);
    goto(c);
    i_div_wr     = 1'b1;
    i_div_value  = 16'(d);
    i_frac_value = 4'(f);
    goto(c + 1);
    i_div_wr = 1'b0;
  endtask

  task automatic drain();
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default divisor: ticks every 326 cycles, first bit tick at 5216
    do_reset(1'b1);
    for (int k = 1; k <= 16; k++) push(326 * k, k == 16);
    goto(5220);
    drain();
    chk("default_div_active", int'(o_div_active), 326);

    // Divisor write mid-period, last write wins, applied at the tick
    do_reset(1'b1);
    push(326, 1'b0);
    push(977, 1'b0);
    wr(50, 500, 0);
    wr(100, 651, 0);
    chk("pending_not_active", int'(o_div_active), 326);
    goto(326);
    chk("old_div_until_tick", int'(o_div_active), 326);
    goto(327);
    chk("new_div_after_tick", int'(o_div_active), 651);
    goto(980);
    drain();

    // Enable low for 50 cycles while counter = 200
    do_reset(1'b1);
    push(376, 1'b0);
    push(702, 1'b0);
    goto(201);
    i_enable = 1'b0;
    goto(251);
    i_enable = 1'b1;
    goto(705);
    drain();

    // Resync at cycle 1000 with phase 3
    do_reset(1'b1);
    push(326, 1'b0);
    push(652, 1'b0);
    push(978, 1'b0);
    for (int k = 0; k < 16; k++) push(1326 + 326 * k, k == 15);
    goto(1000);
    i_resync = 1'b1;
    goto(1001);
    i_resync = 1'b0;
    goto(6220);
    drain();

    // Divisor 0, then 1 written on a tick cycle: tick every enabled cycle
    do_reset(1'b0);
    for (int c = 3; c <= 66; c++) push(c, ((c - 3) % 16) == 15);
    wr(1, 0, 0);
    chk("div0_applied_as_1", int'(o_div_active), 1);
    goto(3);
    i_enable = 1'b1;
    wr(35, 1, 0);
    chk("div1_active", int'(o_div_active), 1);
    goto(67);
    i_enable = 1'b0;
    goto(70);
    drain();

    // Divisor 10 (fraction ignored): 16 ticks within 160 cycles (3..162)
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) push(12 + 10 * k, k == 15);
    wr(1, 10, 8);
    chk("div10_active", int'(o_div_active), 10);
    goto(3);
    i_enable = 1'b1;
    goto(165);
    i_enable = 1'b0;
    goto(167);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
